// File: rtl/signed_accum_sat.sv
// signed_accum_sat
// ----------------
// Streaming two's-complement accumulator. Operands arrive one per beat over a
// valid/ready input handshake. Each beat is added to a WIDTH-bit running sum.
// When an addition overflows, the sum either clamps to the signed limit
// (SATURATE=1) or wraps modulo 2^WIDTH (SATURATE=0). The beat flagged in_last
// closes the frame. The frame sum and a sticky overflow flag are then offered
// on a valid/ready output handshake. The block accepts no new operand until
// that result has been taken.
//
// Parameters
//   WIDTH     operand / accumulator width in bits (>= 2)
//   SATURATE  1 = clamp on overflow, 0 = wrap
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   clear         synchronous frame abort, overrides every handshake
//   in_valid      operand beat valid
//   in_ready      block can accept an operand
//   in_data       signed operand
//   in_last       final operand of the frame (qualified by in_valid)
//   out_valid     frame result valid
//   out_ready     downstream accepts the result
//   out_sum       signed frame sum
//   out_overflow  at least one addition in the frame overflowed
module signed_accum_sat #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_overflow
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             oflag_q, oflag_d;

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] result;
  logic             ov;
  logic             take;

  // Gating with rst_n holds in_ready low during reset. The state register
  // alone would show ACCUM at that point.
  assign in_ready     = rst_n && (state_q == ACCUM);
  assign out_valid    = (state_q == HOLD);
  assign out_sum      = sum_q;
  assign out_overflow = oflag_q;
  assign take         = in_valid && in_ready;

  // Two's-complement overflow can only occur when both operands have the same
  // sign and the sum's sign differs from it. The sign of acc picks the clamp
  // direction because it equals the sign of in_data whenever ov is set.
  always_comb begin
    raw    = acc_q + in_data;
    ov     = (acc_q[WIDTH-1] == in_data[WIDTH-1]) && (raw[WIDTH-1] != acc_q[WIDTH-1]);
    result = raw;
    if (ov && SATURATE) begin
      result = acc_q[WIDTH-1] ? MIN_NEG : MAX_POS;
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    oflag_d = oflag_q;

    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
      sum_d   = '0;
      oflag_d = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (take) begin
            if (in_last) begin
              sum_d   = result;
              oflag_d = ovf_q | ov;
              acc_d   = '0;
              ovf_d   = 1'b0;
              state_d = HOLD;
            end else begin
              acc_d = result;
              ovf_d = ovf_q | ov;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      oflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      oflag_q <= oflag_d;
    end
  end

endmodule
